// File: rtl/mine_placer.sv
// Round-start bomb placer: clears the grid, then draws LFSR indices until
// NUM_BOMBS distinct cells (never the protected safe cell) hold a bomb.
module mine_placer #(
  parameter int         GRID_SIZE = 9,
  parameter int         NUM_BOMBS = 10,
  parameter logic [7:0] SEED      = 8'hA5
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             start,
  input  logic [7:0]                       safeIdx,
  output logic [GRID_SIZE*GRID_SIZE-1:0]   bombGrid,
  output logic [7:0]                       placed,
  output logic                             busy,
  output logic                             done
);

  localparam int         CELLS     = GRID_SIZE * GRID_SIZE;
  localparam logic [7:0] LFSR_INIT = (SEED == 8'h00) ? 8'h01 : SEED;
  localparam logic [7:0] NB        = 8'(NUM_BOMBS);
  localparam logic [8:0] CELLS_W   = 9'(CELLS);

  typedef enum logic [1:0] {IDLE, CLEAR, DRAW, DONE} state_t;

  state_t           state, state_nxt;
  logic [7:0]       lfsr, cand, safe_q;
  logic [CELLS-1:0] sel;
  logic             in_range, occupied, accept, last;

  // Free-running: keeps advancing across rounds so consecutive rounds differ.
  always_ff @(posedge clock) begin
    if (!reset) lfsr <= LFSR_INIT;
    else        lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end

  assign cand = lfsr - 8'd1;

  // One-hot decode of the candidate; all zero when cand is off the board.
  for (genvar i = 0; i < CELLS; i++) begin : g_sel
    assign sel[i] = (cand == 8'(i));
  end

  assign in_range = {1'b0, cand} < CELLS_W;
  assign occupied = |(sel & bombGrid);
  assign accept   = (state == DRAW) && in_range && !occupied && (cand != safe_q);
  assign last     = (placed + 8'd1) == NB;

  always_ff @(posedge clock) begin
    if (!reset || state == CLEAR) bombGrid <= '0;
    else if (accept)              bombGrid <= bombGrid | sel;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      safe_q <= 8'd0;
      placed <= 8'd0;
    end else begin
      if (state == IDLE && start) safe_q <= safeIdx;
      if (state == CLEAR)         placed <= 8'd0;
      else if (accept)            placed <= placed + 8'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = CLEAR;
      CLEAR: state_nxt = (NUM_BOMBS == 0) ? DONE : DRAW;
      DRAW:  if (accept && last) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == CLEAR) || (state == DRAW);
    done = (state == DONE);
  end

endmodule

// File: tb/tb_mine_placer.sv
// Directed bench for mine_placer: golden LFSR model predicts grid and done cycle.
module tb_mine_placer;
  localparam int CELLS = 81;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic [3:0]       start = '0;
  logic [7:0]       safe   [4];
  logic [CELLS-1:0] grid   [4];
  logic [7:0]       placed [4];
  logic             busy   [4];
  logic             done   [4];
  int total = 0, bad = 0, cyc = 0, rst_edge = 0;

  always #5 clock = ~clock;

  mine_placer #(.GRID_SIZE(9), .NUM_BOMBS(10), .SEED(8'hA5)) u_dflt (
    .clock(clock), .reset(reset), .start(start[0]), .safeIdx(safe[0]),
    .bombGrid(grid[0]), .placed(placed[0]), .busy(busy[0]), .done(done[0]));
  mine_placer #(.GRID_SIZE(9), .NUM_BOMBS(10), .SEED(8'h00)) u_seed0 (
    .clock(clock), .reset(reset), .start(start[1]), .safeIdx(safe[1]),
    .bombGrid(grid[1]), .placed(placed[1]), .busy(busy[1]), .done(done[1]));
  mine_placer #(.GRID_SIZE(9), .NUM_BOMBS(0), .SEED(8'hA5)) u_nb0 (
    .clock(clock), .reset(reset), .start(start[2]), .safeIdx(safe[2]),
    .bombGrid(grid[2]), .placed(placed[2]), .busy(busy[2]), .done(done[2]));
  mine_placer #(.GRID_SIZE(9), .NUM_BOMBS(80), .SEED(8'hA5)) u_nb80 (
    .clock(clock), .reset(reset), .start(start[3]), .safeIdx(safe[3]),
    .bombGrid(grid[3]), .placed(placed[3]), .busy(busy[3]), .done(done[3]));

  function automatic logic [7:0] step(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    cyc++;
    #1;
  endtask

  // adv = LFSR steps from the reset value to the value seen at the first DRAW edge.
  task automatic model(input logic [7:0] seed, input int adv, input logic [7:0] sfe,
                       input int nb, output logic [CELLS-1:0] g, output int k);
    logic [7:0] l, c;
    int p;
    l = (seed == 8'h00) ? 8'h01 : seed;
    for (int i = 0; i < adv; i++) l = step(l);
    g = '0; k = 0; p = 0;
    while (p < nb) begin
      c = l - 8'd1;
      if (c < CELLS && !g[c] && c != sfe) begin
        g[c] = 1'b1;
        p++;
      end
      k++;
      l = step(l);
    end
  endtask

  task automatic launch(input int idx, input logic [7:0] s, output int t);
    safe[idx]  = s;
    start[idx] = 1'b1;
    t = cyc + 1;
    tick();
    start[idx] = 1'b0;
  endtask

  task automatic run_round(input int idx, input int t, input logic [7:0] sfe, input int nb,
                           input logic [7:0] seed, input bit poke, input string tag);
    logic [CELLS-1:0] eg;
    int k, lim;
    bit busy_ok;
    busy_ok = 1'b1;
    model(seed, t - rst_edge + 1, sfe, nb, eg, k);
    lim = t + 10 + 255 * nb;
    while (!done[idx] && cyc < lim) begin
      if (!busy[idx]) busy_ok = 1'b0;
      start[idx] = poke && (cyc == t + 4);
      tick();
    end
    start[idx] = 1'b0;
    chk({tag, "_done"},    done[idx], 1);
    chk({tag, "_latency"}, cyc, t + 1 + k);
    chk({tag, "_busy_at_done"}, busy[idx], 0);
    chk({tag, "_busy_during"},  busy_ok, 1);
    chk({tag, "_grid"},    grid[idx], eg);
    chk({tag, "_placed"},  placed[idx], nb);
    chk({tag, "_popcount"}, $countones(grid[idx]), nb);
    if (sfe < CELLS) chk({tag, "_safe_free"}, grid[idx][sfe], 0);
    tick();
    chk({tag, "_done_pulse"}, done[idx], 0);
    chk({tag, "_idle_busy"},  busy[idx], 0);
    chk({tag, "_grid_hold"},  grid[idx], eg);
  endtask

  initial begin
    int t, dcnt;
    logic [CELLS-1:0] all_but0;
    for (int i = 0; i < 4; i++) safe[i] = 8'd0;
    repeat (3) tick();
    rst_edge = cyc;
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("rst_grid",   grid[i], 0);
      chk("rst_placed", placed[i], 0);
      chk("rst_busy",   busy[i], 0);
      chk("rst_done",   done[i], 0);
    end

    launch(0, 8'd40, t); run_round(0, t, 8'd40, 10, 8'hA5, 1'b0, "dflt");
    launch(1, 8'd40, t); run_round(1, t, 8'd40, 10, 8'h00, 1'b0, "seed0");

    launch(2, 8'd5, t);
    tick();
    chk("nb0_done_t2", done[2], 1);
    chk("nb0_grid",    grid[2], 0);
    chk("nb0_placed",  placed[2], 0);

    launch(3, 8'd0, t); run_round(3, t, 8'd0, 80, 8'hA5, 1'b0, "nb80");
    all_but0 = '1;
    all_but0[0] = 1'b0;
    chk("nb80_full", grid[3], all_but0);

    launch(0, 8'd12, t); run_round(0, t, 8'd12, 10, 8'hA5, 1'b1, "poke");
    dcnt = 0;
    repeat (6) begin
      if (done[0]) dcnt++;
      tick();
    end
    chk("poke_extra_done", dcnt, 0);

    // Held start: first edge accepts, the next two land in CLEAR/DRAW and are ignored.
    safe[0]  = 8'd77;
    start[0] = 1'b1;
    t = cyc + 1;
    repeat (3) tick();
    start[0] = 1'b0;
    chk("held_busy", busy[0], 1);
    run_round(0, t, 8'd77, 10, 8'hA5, 1'b0, "held");

    launch(0, 8'd40, t);
    repeat (5) tick();
    chk("mid_busy", busy[0], 1);
    reset = 1'b0;
    tick();
    rst_edge = cyc;
    reset = 1'b1;
    chk("midrst_grid",   grid[0], 0);
    chk("midrst_placed", placed[0], 0);
    chk("midrst_busy",   busy[0], 0);
    chk("midrst_done",   done[0], 0);
    launch(0, 8'd200, t); run_round(0, t, 8'd200, 10, 8'hA5, 1'b0, "after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
